ca_frame_arbiter: RTL and testbench

- Owns the single-port cell-state RAM.
- Shares the RAM between the display prefetch reader (slaved to the 1280x1024 sync generator's inPrefetchArea/prefetchCounterX/counterY) and the cellular-automaton update engine.
- Double-buffers generations: display reads the current bank while the CA engine reads current and writes next.
- Schedules generation start and bank flips at vertical-blank entry.

---
 rtl/ca_frame_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_ca_frame_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_frame_arbiter.sv
// ca_frame_arbiter: owns the single-port cell-state RAM and shares it between the
// display prefetch reader and the cellular-automaton update engine.
//
// Generations are double-buffered: the display reads bank disp_bank, while the CA
// engine reads disp_bank and writes ~disp_bank. Bank flips and generation starts are
// scheduled at vertical-blank entry, so a displayed frame never mixes banks.
//
// Ports:
//   clk, rst_n                  pixel clock, asynchronous active-low reset
//   i_in_prefetch_area          sync generator: prefetch window active
//   i_prefetch_x, i_counter_y   sync generator: prefetch column and current line
//   o_disp_word/_valid          fetched display word and one-cycle update pulse
//   i_ca_req/_we/_addr/_wdata   CA engine access (held stable until o_ca_gnt)
//   o_ca_gnt                    combinational grant
//   o_ca_rvalid, o_ca_rdata     CA read return (o_ca_rdata is i_mem_rdata)
//   o_gen_start, i_gen_done     generation handshake pulses
//   o_frame_drop                vblank reached while a generation was still running
//   o_disp_bank                 bank currently displayed
//   o_mem_*, i_mem_rdata        registered RAM strobes/address/data, read data
//
// Optional feature (macro CA_ARB_STATS_EN):
//   o_drop_count        saturating count of frame_drop pulses
//   o_ca_stall_cycles   saturating count of denied CA request cycles, cleared on gen_start

module ca_frame_arbiter #(
  parameter int unsigned VISIBLE_H     = 1024,
  parameter int unsigned WORD_BITS     = 16,
  parameter int unsigned Y_BITS        = 10,
  parameter int unsigned ROW_ADDR_BITS = 7,
  parameter int unsigned MEM_LAT       = 1,
  localparam int unsigned WB_LOG       = $clog2(WORD_BITS),
  localparam int unsigned AW           = 1 + Y_BITS + ROW_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_prefetch_area,
  input  logic [10:0]          i_prefetch_x,
  input  logic [10:0]          i_counter_y,
  output logic [WORD_BITS-1:0] o_disp_word,
  output logic                 o_disp_word_valid,
  input  logic                 i_ca_req,
  input  logic                 i_ca_we,
  input  logic [AW-2:0]        i_ca_addr,
  input  logic [WORD_BITS-1:0] i_ca_wdata,
  output logic                 o_ca_gnt,
  output logic                 o_ca_rvalid,
  output logic [WORD_BITS-1:0] o_ca_rdata,
  output logic                 o_gen_start,
  input  logic                 i_gen_done,
  output logic                 o_frame_drop,
  output logic                 o_disp_bank,
  output logic                 o_mem_en,
  output logic                 o_mem_we,
  output logic [AW-1:0]        o_mem_addr,
  output logic [WORD_BITS-1:0] o_mem_wdata,
  input  logic [WORD_BITS-1:0] i_mem_rdata
`ifdef CA_ARB_STATS_EN
  ,
  output logic [15:0]          o_drop_count,
  output logic [15:0]          o_ca_stall_cycles
`endif
);

  localparam logic [10:0] VBL_LINE = 11'(VISIBLE_H);

  localparam logic [0:0] ST_WAIT_VBL = 1'b0;
  localparam logic [0:0] ST_GEN      = 1'b1;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_CA   = 2'd2;

  // ---------------------------------------------------------------------------
  // Slot arbitration: the display slot always wins the RAM port.
  // ---------------------------------------------------------------------------
  logic                     w_disp_slot;
  logic                     w_ca_gnt;
  logic [ROW_ADDR_BITS-1:0] w_row_word;
  logic [1:0]               w_tag_in;

  assign w_disp_slot = i_in_prefetch_area && (i_prefetch_x[WB_LOG-1:0] == '0);
  assign w_ca_gnt    = i_ca_req && !w_disp_slot;
  assign w_row_word  = ROW_ADDR_BITS'(i_prefetch_x >> WB_LOG);
  assign o_ca_gnt    = w_ca_gnt;

  // Writes carry no tag; only reads come back through the return pipeline.
  always_comb begin
    w_tag_in = TAG_NONE;
    if (w_disp_slot) begin
      w_tag_in = TAG_DISP;
    end else if (w_ca_gnt && !i_ca_we) begin
      w_tag_in = TAG_CA;
    end
  end

  logic                 r_disp_bank;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [AW-1:0]        r_mem_addr;
  logic [WORD_BITS-1:0] r_mem_wdata;

  // Bank bit is sampled at issue, so an access in flight across a flip keeps its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_disp_slot) begin
      r_mem_en   <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= {r_disp_bank, i_counter_y[Y_BITS-1:0], w_row_word};
    end else if (w_ca_gnt) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= i_ca_we;
      r_mem_addr  <= {(i_ca_we ? ~r_disp_bank : r_disp_bank), i_ca_addr};
      r_mem_wdata <= i_ca_wdata;
    end else begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

  // ---------------------------------------------------------------------------
  // Read return: r_tag[MEM_LAT] lines up with the cycle i_mem_rdata is valid.
  // ---------------------------------------------------------------------------
  logic [1:0]           r_tag [MEM_LAT+1];
  logic [WORD_BITS-1:0] r_disp_word;
  logic                 r_disp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(MEM_LAT); i++) begin
        r_tag[i] <= TAG_NONE;
      end
    end else begin
      r_tag[0] <= w_tag_in;
      for (int i = 1; i <= int'(MEM_LAT); i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_word  <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_disp_valid <= (r_tag[MEM_LAT] == TAG_DISP);
      if (r_tag[MEM_LAT] == TAG_DISP) begin
        r_disp_word <= i_mem_rdata;
      end
    end
  end

  assign o_disp_word       = r_disp_word;
  assign o_disp_word_valid = r_disp_valid;
  assign o_ca_rvalid       = (r_tag[MEM_LAT] == TAG_CA);
  assign o_ca_rdata        = i_mem_rdata;

  // ---------------------------------------------------------------------------
  // Generation scheduling at vblank entry.
  // ---------------------------------------------------------------------------
  logic [10:0] r_counter_y;
  logic        w_vbl_entry;

  assign w_vbl_entry = (i_counter_y == VBL_LINE) && (r_counter_y != VBL_LINE);

  logic [0:0] r_state;
  logic [0:0] w_state_d;
  logic       w_flip;
  logic       w_gen_start;
  logic       w_frame_drop;

  always_comb begin
    w_state_d    = r_state;
    w_flip       = 1'b0;
    w_gen_start  = 1'b0;
    w_frame_drop = 1'b0;
    case (r_state)
      ST_WAIT_VBL: begin
        if (w_vbl_entry) begin
          w_flip      = 1'b1;
          w_gen_start = 1'b1;
          w_state_d   = ST_GEN;
        end
      end
      ST_GEN: begin
        // A generation that finishes on the vblank cycle itself still misses this frame.
        if (i_gen_done) begin
          w_state_d = ST_WAIT_VBL;
        end
        if (w_vbl_entry) begin
          w_frame_drop = 1'b1;
        end
      end
      default: w_state_d = ST_WAIT_VBL;
    endcase
  end

  logic r_gen_start;
  logic r_frame_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter_y  <= '0;
      r_state      <= ST_WAIT_VBL;
      r_disp_bank  <= 1'b1;
      r_gen_start  <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_counter_y  <= i_counter_y;
      r_state      <= w_state_d;
      r_gen_start  <= w_gen_start;
      r_frame_drop <= w_frame_drop;
      if (w_flip) begin
        r_disp_bank <= ~r_disp_bank;
      end
    end
  end

  assign o_gen_start  = r_gen_start;
  assign o_frame_drop = r_frame_drop;
  assign o_disp_bank  = r_disp_bank;

`ifdef CA_ARB_STATS_EN
  logic [15:0] r_drop_count;
  logic [15:0] r_ca_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_count      <= '0;
      r_ca_stall_cycles <= '0;
    end else begin
      if (w_frame_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
      if (w_gen_start) begin
        r_ca_stall_cycles <= '0;
      end else if (i_ca_req && !w_ca_gnt && (r_ca_stall_cycles != 16'hFFFF)) begin
        r_ca_stall_cycles <= r_ca_stall_cycles + 16'd1;
      end
    end
  end

  assign o_drop_count      = r_drop_count;
  assign o_ca_stall_cycles = r_ca_stall_cycles;
`endif

endmodule

// File: tb/tb_ca_frame_arbiter.sv
module tb_ca_frame_arbiter;

  logic        clk;
  logic        rst_n;
  logic        in_area;
  logic [10:0] px;
  logic [10:0] cy;
  logic [15:0] disp_word;
  logic        disp_valid;
  logic        ca_req;
  logic        ca_we;
  logic [16:0] ca_addr;
  logic [15:0] ca_wdata;
  logic        ca_gnt;
  logic        ca_rvalid;
  logic [15:0] ca_rdata;
  logic        gen_start;
  logic        gen_done;
  logic        frame_drop;
  logic        disp_bank;
  logic        mem_en;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
`ifdef CA_ARB_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] stall_cycles;
`endif

  int n_chk = 0;
  int n_err = 0;

  ca_frame_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_in_prefetch_area(in_area),
    .i_prefetch_x      (px),
    .i_counter_y       (cy),
    .o_disp_word       (disp_word),
    .o_disp_word_valid (disp_valid),
    .i_ca_req          (ca_req),
    .i_ca_we           (ca_we),
    .i_ca_addr         (ca_addr),
    .i_ca_wdata        (ca_wdata),
    .o_ca_gnt          (ca_gnt),
    .o_ca_rvalid       (ca_rvalid),
    .o_ca_rdata        (ca_rdata),
    .o_gen_start       (gen_start),
    .i_gen_done        (gen_done),
    .o_frame_drop      (frame_drop),
    .o_disp_bank       (disp_bank),
    .o_mem_en          (mem_en),
    .o_mem_we          (mem_we),
    .o_mem_addr        (mem_addr),
    .o_mem_wdata       (mem_wdata),
    .i_mem_rdata       (mem_rdata)
`ifdef CA_ARB_STATS_EN
    ,
    .o_drop_count      (drop_count),
    .o_ca_stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model, 1-cycle read latency; unwritten words read as addr[15:0] ^ 16'hA5A5.
  logic [15:0] mem [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[int'(mem_addr)] = mem_wdata;
      end else begin
        mem_rdata <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)]
                                                : (mem_addr[15:0] ^ 16'hA5A5);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    gen_done = 1'b1;
    step();
    gen_done = 1'b0;
  endtask

  // Produces one vblank entry and checks the resulting pulses and bank.
  task automatic vbl(input string tag, input logic exp_start, input logic exp_drop,
                     input logic exp_bank, input logic with_done);
    cy = 11'd0;
    step();
    cy = 11'd1024;
    gen_done = with_done;
    step();
    gen_done = 1'b0;
    check({tag, "_gen_start"}, 32'(gen_start), 32'(exp_start));
    check({tag, "_frame_drop"}, 32'(frame_drop), 32'(exp_drop));
    check({tag, "_bank"}, 32'(disp_bank), 32'(exp_bank));
    step();
    check({tag, "_pulse_end"}, 32'({gen_start, frame_drop}), 32'd0);
    cy = 11'd0;
  endtask

  int n_en;
  int n_val;

  initial begin
    rst_n = 1'b0; in_area = 1'b0; px = '0; cy = '0;
    ca_req = 1'b0; ca_we = 1'b0; ca_addr = '0; ca_wdata = '0; gen_done = 1'b0;
    step();
    step();
    check("rst_bank", 32'(disp_bank), 32'd1);
    check("rst_outs", 32'({mem_en, mem_we, gen_start, frame_drop, disp_valid, ca_rvalid}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
`ifdef CA_ARB_STATS_EN
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // First vblank: bank 1 -> 0 with gen_start.
    vbl("vbl1", 1'b1, 1'b0, 1'b0, 1'b0);
    pulse_done();

    // Display slot at y=5, x=32: address {0, 5, 2}, data 0x0282 ^ 0xA5A5.
    in_area = 1'b1; px = 11'd32; cy = 11'd5;
    step();
    check("disp_en", 32'({mem_en, mem_we}), 32'b10);
    check("disp_addr", 32'(mem_addr), 32'h00282);
    px = 11'd33;
    step();
    check("disp_idle", 32'({mem_en, disp_valid}), 32'd0);
    check("disp_addr_hold", 32'(mem_addr), 32'h00282);
    step();
    check("disp_valid", 32'(disp_valid), 32'd1);
    check("disp_word", 32'(disp_word), 32'hA727);
    in_area = 1'b0;
    step();
    check("disp_valid_once", 32'(disp_valid), 32'd0);

    // CA read blocked by slot at x=48 (y=6), granted next cycle.
    in_area = 1'b1; px = 11'd48; cy = 11'd6;
    ca_req = 1'b1; ca_we = 1'b0; ca_addr = 17'h00123;
    #1;
    check("ca_gnt_blocked", 32'(ca_gnt), 32'd0);
    step();
    px = 11'd49;
    #1;
    check("ca_gnt", 32'(ca_gnt), 32'd1);
    step();
    ca_req = 1'b0; in_area = 1'b0;
    check("ca_rd_addr", 32'(mem_addr), 32'h00123);
    check("ca_rd_we", 32'({mem_en, mem_we}), 32'b10);
    check("ca_rvalid_early", 32'(ca_rvalid), 32'd0);
    step();
    check("ca_rvalid", 32'(ca_rvalid), 32'd1);
    check("ca_rdata", 32'(ca_rdata), 32'hA486);
    check("disp_word_x48", 32'({disp_valid, disp_word}), 32'h1A6A6);
    step();
    check("ca_rvalid_once", 32'(ca_rvalid), 32'd0);

    // CA write to next bank, then display reads bank 0 of the same word.
    ca_req = 1'b1; ca_we = 1'b1; ca_addr = 17'h00155; ca_wdata = 16'hBEEF;
    #1;
    check("ca_wr_gnt", 32'(ca_gnt), 32'd1);
    step();
    ca_req = 1'b0; ca_we = 1'b0;
    check("ca_wr_strobe", 32'({mem_en, mem_we}), 32'b11);
    check("ca_wr_addr", 32'(mem_addr), 32'h20155);
    check("ca_wr_data", 32'(mem_wdata), 32'hBEEF);
    step();
    check("ca_wr_idle", 32'({mem_en, mem_we}), 32'd0);
    check("ca_wr_no_rvalid", 32'(ca_rvalid), 32'd0);
    in_area = 1'b1; px = 11'd1360; cy = 11'd2;
    step();
    in_area = 1'b0;
    check("disp_row2_addr", 32'(mem_addr), 32'h00155);
    step();
    step();
    check("disp_bank0_data", 32'({disp_valid, disp_word}), 32'h1A4F0);

    // Full line: 80 display reads over x = 0..1279.
    n_en = 0; n_val = 0; cy = 11'd7; in_area = 1'b1;
    for (int x = 0; x < 1280; x++) begin
      px = 11'(x);
      step();
      if (mem_en) n_en++;
      if (disp_valid) n_val++;
    end
    in_area = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (mem_en) n_en++;
      if (disp_valid) n_val++;
    end
    check("line_mem_en", 32'(n_en), 32'd80);
    check("line_disp_valid", 32'(n_val), 32'd80);

    // Scheduling: flip, drop, recover, coincident done+vblank.
    vbl("vbl2", 1'b1, 1'b0, 1'b1, 1'b0);
    vbl("vbl3_drop", 1'b0, 1'b1, 1'b1, 1'b0);
    pulse_done();
    vbl("vbl4", 1'b1, 1'b0, 1'b0, 1'b0);
    vbl("vbl5_coinc", 1'b0, 1'b1, 1'b0, 1'b1);
    vbl("vbl6", 1'b1, 1'b0, 1'b1, 1'b0);
    pulse_done();
    vbl("vbl7", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef CA_ARB_STATS_EN
    check("drop_count", 32'(drop_count), 32'd2);
`endif

    // Reset with a display read and a CA read in flight.
    in_area = 1'b1; px = 11'd0; cy = 11'd0;
    step();
    px = 11'd1; ca_req = 1'b1; ca_we = 1'b0; ca_addr = 17'h00005;
    step();
    ca_req = 1'b0; in_area = 1'b0;
    rst_n = 1'b0;
    n_val = 0;
    #1;
    if (disp_valid || ca_rvalid) n_val++;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (disp_valid || ca_rvalid) n_val++;
      step();
    end
    check("rst_no_returns", 32'(n_val), 32'd0);
    check("rst_mid_bank", 32'(disp_bank), 32'd1);
    check("rst_mid_mem_en", 32'(mem_en), 32'd0);
`ifdef CA_ARB_STATS_EN
    check("rst_mid_drop_count", 32'(drop_count), 32'd0);
`endif
    vbl("vbl_after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
